adc_sample_reader: RTL

//   Downstream consumer of digital_filter: on each new_data pulse it runs one read frame

---
 rtl/adc_sample_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/adc_sample_reader.sv
// Purpose:      Captures one DATA_W-bit serial frame (MSB first) from the filter on each falling edge of
//               new_data, and queues the captured words in a show-ahead FIFO for the host.
// Latency:      cs_n falls START_DLY+1 cycles after new_data falls. The FIFO push happens on the edge where cs_n rises.
// Backpressure: m_valid/m_ready drain the FIFO. A word captured while the FIFO is full is dropped, unless a
//               pop happens on the same edge. A dropped word sets overflow. A trigger seen while busy sets missed.
// Ports:
//   clk, rst_n             clock; synchronous active-low reset
//   new_data, sdi          trigger flag (falling edge) and serial data from the filter
//   cs_n, sclk             serial port controls toward the filter
//   m_data, m_valid        FIFO head word and its valid flag
//   m_ready                consumer accepts the head word
//   fifo_count             number of words held
//   busy, missed, overflow frame in progress; sticky error flags
//   flag_clr               one-cycle pulse that clears missed and overflow
module adc_sample_reader #(
    parameter int DATA_W     = 12,
    parameter int START_DLY  = 4,
    parameter int CS_SETUP   = 5,
    parameter int SCLK_HALF  = 5,
    parameter int CS_HOLD    = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          new_data,
    input  logic                          sdi,
    output logic                          cs_n,
    output logic                          sclk,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          missed,
    output logic                          overflow,
    input  logic                          flag_clr
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int M1      = (START_DLY > CS_SETUP) ? START_DLY : CS_SETUP;
    localparam int M2      = (SCLK_HALF > CS_HOLD) ? SCLK_HALF : CS_HOLD;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] WAIT_LAST  = CW'(START_DLY - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETUP, S_HI, S_LO, S_HOLD} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [BW-1:0]      bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic               nd_q;
    logic               trig;
    logic               push, pop, full, wr_en;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [DATA_W-1:0]  mem [FIFO_DEPTH];

    assign trig = nd_q & ~new_data;

    // Next-state and port outputs. The outputs decode the state register only, so they are glitch-free.
    always_comb begin
        state_nxt = state;
        cs_n      = 1'b1;
        sclk      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (trig) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == WAIT_LAST) state_nxt = S_SETUP;
            S_SETUP: begin
                cs_n = 1'b0;
                if (cnt == SETUP_LAST) state_nxt = S_HI;
            end
            S_HI: begin
                cs_n = 1'b0;
                sclk = 1'b1;
                if (cnt == HALF_LAST) state_nxt = S_LO;
            end
            S_LO: begin
                cs_n = 1'b0;
                if (cnt == HALF_LAST) state_nxt = (bit_cnt == BW'(DATA_W)) ? S_HOLD : S_HI;
            end
            S_HOLD: begin
                cs_n = 1'b0;
                if (cnt == HOLD_LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The completed word is pushed on the same edge that leaves HOLD, which is the edge where cs_n rises.
    assign push    = (state == S_HOLD) && (cnt == HOLD_LAST);
    assign m_valid = (fifo_count != '0);
    assign pop     = m_valid & m_ready;
    assign full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
    // When the FIFO is full, a pop on the same edge frees the slot that this push reuses.
    assign wr_en   = push & (~full | pop);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            nd_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            nd_q  <= new_data;
            // The phase counter restarts at every state change and sits at zero while idle.
            if (state_nxt != state || state == S_IDLE) cnt <= '0;
            else                                       cnt <= cnt + CW'(1);
            if (state == S_IDLE) bit_cnt <= '0;
            // Sample sdi once, on the first cycle of each sclk-high phase.
            if (state == S_HI && cnt == '0) begin
                shreg   <= {shreg[DATA_W-2:0], sdi};
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            missed     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
            // A set event has priority over a clear in the same cycle.
            if (trig && state != S_IDLE) missed <= 1'b1;
            else if (flag_clr)           missed <= 1'b0;
            if (push && full && !pop)    overflow <= 1'b1;
            else if (flag_clr)           overflow <= 1'b0;
        end
    end

    // Storage is not reset. The pointers and the count define which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

endmodule
